// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - chains NUM_STAGES layers: launch, wait done, stream outmem into next inmem.
// Optional perf counters (perf_cycles, perf_stall) under LAYER_SEQUENCER_PERF_EN.
module layer_sequencer #(
    parameter int                        NUM_STAGES  = 3,
    parameter int                        IDX_W       = 16,
    parameter logic [NUM_STAGES*16-1:0]  OUT_CH_VEC  = {16'd16, 16'd16, 16'd16},
    parameter logic [NUM_STAGES*16-1:0]  OUT_DIM_VEC = {16'd13, 16'd13, 16'd26},
    parameter int                        READ_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [NUM_STAGES-1:0]         stage_start,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [3*IDX_W-1:0]            rd_index,
    output logic [$clog2(NUM_STAGES)-1:0] rd_stage,
    output logic [3*IDX_W-1:0]            wr_index,
    output logic [NUM_STAGES-1:0]         wr_en,
    output logic                          busy,
`ifdef LAYER_SEQUENCER_PERF_EN
    output logic [31:0]                   perf_cycles,
    output logic [31:0]                   perf_stall,
`endif
    output logic                          done
);
    localparam int SW = $clog2(NUM_STAGES);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_XFER, S_DRAIN, S_DONE
    } state_t;

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("layer_sequencer: NUM_STAGES must be at least 2");
    end
    if (READ_LAT < 0 || READ_LAT > 4) begin : g_bad_lat
        $error("layer_sequencer: READ_LAT must be 0..4");
    end

    logic [IDX_W-1:0] ch_last [NUM_STAGES];
    logic [IDX_W-1:0] dim_last [NUM_STAGES];

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_geom
        if (OUT_CH_VEC[g*16 +: 16] == 16'd0 || OUT_DIM_VEC[g*16 +: 16] == 16'd0 ||
            (32'(OUT_CH_VEC[g*16 +: 16]) >> IDX_W) != 32'd0 ||
            (32'(OUT_DIM_VEC[g*16 +: 16]) >> IDX_W) != 32'd0) begin : g_bad_geom
            $error("layer_sequencer: illegal channel/dim for a stage");
        end
        assign ch_last[g]  = IDX_W'(OUT_CH_VEC[g*16 +: 16] - 16'd1);
        assign dim_last[g] = IDX_W'(OUT_DIM_VEC[g*16 +: 16] - 16'd1);
    end

    state_t                  state_q, state_d;
    logic [SW-1:0]           k_q, k_d;
    logic [IDX_W-1:0]        ch_q, ch_d, row_q, row_d, col_q, col_d;
    logic [2:0]              drain_q, drain_d;
    logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
    logic                    rd_fire;
    logic                    wr_valid;
    logic [SW-1:0]           wr_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            ch_q          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            drain_q       <= '0;
            stage_start_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            ch_q          <= ch_d;
            row_q         <= row_d;
            col_q         <= col_d;
            drain_q       <= drain_d;
            stage_start_q <= stage_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        ch_d          = ch_q;
        row_d         = row_q;
        col_d         = col_q;
        drain_d       = drain_q;
        stage_start_d = '0;
        rd_fire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LAUNCH;
                    k_d     = '0;
                end
            end
            S_LAUNCH: begin
                // Registered pulse: visible during the first WAIT cycle.
                stage_start_d[k_q] = 1'b1;
                state_d            = S_WAIT;
            end
            S_WAIT: begin
                if (stage_done[k_q]) begin
                    if (k_q == SW'(NUM_STAGES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_XFER;
                        ch_d    = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
            end
            S_XFER: begin
                rd_fire = 1'b1;
                if (col_q == dim_last[k_q]) begin
                    col_d = '0;
                    if (row_q == dim_last[k_q]) begin
                        row_d = '0;
                        if (ch_q == ch_last[k_q]) begin
                            ch_d = '0;
                            if (READ_LAT == 0) begin
                                state_d = S_LAUNCH;
                                k_d     = k_q + SW'(1);
                            end else begin
                                state_d = S_DRAIN;
                                drain_d = 3'(READ_LAT - 1);
                            end
                        end else begin
                            ch_d = ch_q + IDX_W'(1);
                        end
                    end else begin
                        row_d = row_q + IDX_W'(1);
                    end
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = S_LAUNCH;
                    k_d     = k_q + SW'(1);
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Index counters sit at zero outside XFER, so rd_index is idle-zero too.
    assign rd_index    = {ch_q, row_q, col_q};
    assign rd_stage    = k_q;
    assign stage_start = stage_start_q;
    assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                         (state_q == S_XFER)   || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign wr_sel      = k_q + SW'(1);

    if (READ_LAT == 0) begin : g_nolat
        assign wr_valid = rd_fire;
        assign wr_index = rd_index;
    end else begin : g_lat
        logic [READ_LAT-1:0] pv_q;
        logic [3*IDX_W-1:0]  pidx_q [READ_LAT];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pv_q <= '0;
                for (int i = 0; i < READ_LAT; i++) pidx_q[i] <= '0;
            end else begin
                pv_q[0]   <= rd_fire;
                pidx_q[0] <= rd_index;
                for (int i = 1; i < READ_LAT; i++) begin
                    pv_q[i]   <= pv_q[i-1];
                    pidx_q[i] <= pidx_q[i-1];
                end
            end
        end

        assign wr_valid = pv_q[READ_LAT-1];
        assign wr_index = pidx_q[READ_LAT-1];
    end

    // DRAIN holds k until the pipe is empty, so k+1 still names the consumer.
    always_comb begin
        wr_en = '0;
        if (wr_valid) wr_en[wr_sel] = 1'b1;
    end

`ifdef LAYER_SEQUENCER_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;
    logic        accept;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy && perf_cycles_q != 32'hFFFF_FFFF) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_q == S_WAIT && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
